// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder with registered sum, carry-out and signed overflow.
// Ports: clk, reset (sync, active-high), a, b, cin -> sum, c_out, overflow.
module ripple_carry_adder #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  // For WIDTH=1 the carry into the MSB is cin itself (c[0]).
  always_ff @(posedge clk) begin
    if (reset) begin
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= s;
      c_out    <= c[WIDTH];
      overflow <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH 1, 2 and 4.
// Stimulus pushes expected results; per-DUT monitors pop and compare.
module tb_ripple_carry_adder;

  logic clk;
  logic rst0, rst1, rst2;
  logic [0:0] a0, b0;
  logic [1:0] a1, b1;
  logic [3:0] a2, b2;
  logic c0, c1, c2;
  logic [0:0] s0;
  logic [1:0] s1;
  logic [3:0] s2;
  logic co0, co1, co2;
  logic ov0, ov1, ov2;

  int n_vec = 0;
  int n_bad = 0;

  logic [65:0] q0[$];
  logic [65:0] q1[$];
  logic [65:0] q2[$];

  ripple_carry_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(rst0), .a(a0), .b(b0), .cin(c0),
    .sum(s0), .c_out(co0), .overflow(ov0)
  );
  ripple_carry_adder #(.WIDTH(2)) u_w2 (
    .clk(clk), .reset(rst1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .c_out(co1), .overflow(ov1)
  );
  ripple_carry_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(rst2), .a(a2), .b(b2), .cin(c2),
    .sum(s2), .c_out(co2), .overflow(ov2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int wid(int d);
    case (d)
      0: return 1;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  // Reference: plain integer addition and signed range test.
  // Packed as {overflow, c_out, sum[63:0]}.
  function automatic logic [65:0] model(
    int w, logic [63:0] av, logic [63:0] bv, logic ci, logic r
  );
    logic [63:0] mask;
    logic [64:0] full;
    logic signed [66:0] sa, sb, res, lim;
    logic [65:0] o;
    o = '0;
    if (r) return o;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    av = av & mask;
    bv = bv & mask;
    full = {1'b0, av} + {1'b0, bv} + {64'd0, ci};
    o[63:0] = full[63:0] & mask;
    o[64] = full[w];
    lim = 67'sd1 <<< (w - 1);
    sa = $signed({3'b0, av});
    sb = $signed({3'b0, bv});
    if (av[w-1]) sa = sa - (lim <<< 1);
    if (bv[w-1]) sb = sb - (lim <<< 1);
    res = sa + sb + $signed({66'd0, ci});
    o[65] = (res > lim - 1) || (res < -lim);
    return o;
  endfunction

  function automatic logic [65:0] get_out(int d);
    logic [65:0] o;
    o = '0;
    case (d)
      0: begin o[0] = s0[0]; o[64] = co0; o[65] = ov0; end
      1: begin o[1:0] = s1; o[64] = co1; o[65] = ov1; end
      default: begin o[3:0] = s2; o[64] = co2; o[65] = ov2; end
    endcase
    return o;
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [65:0] qpop(int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(int d, logic [65:0] e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(
    int d, logic [63:0] av, logic [63:0] bv, logic ci, logic r
  );
    case (d)
      0: begin a0 = av[0:0]; b0 = bv[0:0]; c0 = ci; rst0 = r; end
      1: begin a1 = av[1:0]; b1 = bv[1:0]; c1 = ci; rst1 = r; end
      default: begin
        a2 = av[3:0]; b2 = bv[3:0]; c2 = ci; rst2 = r;
      end
    endcase
  endtask

  // Optional glitch: inputs flip shortly after the falling edge
  // and are restored well before the next rising edge.
  task automatic apply(
    int d, logic [63:0] av, logic [63:0] bv,
    logic ci, logic r, bit g
  );
    @(negedge clk);
    drive(d, av, bv, ci, r);
    qpush(d, model(wid(d), av, bv, ci, r));
    if (g) begin
      #1 drive(d, ~av, ~bv, ~ci, r);
      #2 drive(d, av, bv, ci, r);
    end
  endtask

  task automatic cmp(int d, string nm, logic [65:0] e);
    logic [65:0] o;
    o = get_out(d);
    n_vec++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL %s w=%0d got sum=%0h cout=%b ov=%b exp sum=%0h cout=%b ov=%b",
        nm, wid(d), o[63:0], o[64], o[65], e[63:0], e[64], e[65]);
    end
  endtask

  task automatic mon(int d);
    logic [65:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (qsize(d) > 0) begin
        e = qpop(d);
        cmp(d, "post_edge", e);
        #6;
        cmp(d, "mid_cycle_hold", e);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic seq_w1();
    apply(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      apply(0, i & 1, (i >> 1) & 1, 1'((i >> 2) & 1), 0, 1);
    for (int i = 0; i < 24; i++)
      apply(0, $urandom, $urandom, 1'($urandom),
            ($urandom % 8) == 0, ($urandom % 3) == 0);
  endtask

  task automatic seq_w2();
    apply(1, 3, 3, 1, 1, 0);
    apply(1, 3, 3, 1, 1, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 1, 3, 0, 0, 0);
    apply(1, 3, 3, 1, 0, 0);
    apply(1, 2, 1, 1, 0, 0);
    apply(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      apply(1, $urandom, $urandom, 1'($urandom), 0,
            ($urandom % 4) == 0);
    apply(1, 3, 2, 1, 1, 0);
    apply(1, 2, 3, 1, 0, 0);
    for (int i = 0; i < 30; i++)
      apply(1, $urandom, $urandom, 1'($urandom),
            ($urandom % 10) == 0, ($urandom % 4) == 0);
  endtask

  task automatic seq_w4();
    apply(2, 15, 15, 1, 1, 0);
    for (int i = 0; i < 512; i++)
      apply(2, i & 15, (i >> 4) & 15, 1'((i >> 8) & 1), 0,
            (i % 7) == 0);
    for (int i = 0; i < 30; i++)
      apply(2, $urandom, $urandom, 1'($urandom),
            ($urandom % 10) == 0, ($urandom % 4) == 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(2, 0, 0, 0, 1);
    fork
      seq_w1();
      seq_w2();
      seq_w4();
    join
    for (int k = 0; k < 5; k++) begin
      if (q0.size() + q1.size() + q2.size() == 0) break;
      @(posedge clk);
    end
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain got pending=%0d exp pending=0",
        q0.size() + q1.size() + q2.size());
    end
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 Parameter: WIDTH, default 2, operand width in bits (legal range 1..64).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: a  input  WIDTH  unsigned addend A.
REQ-005 Port: b  input  WIDTH  unsigned addend B.
REQ-006 Port: cin  input  1  carry into bit 0.
REQ-007 Port: sum  output  WIDTH  registered sum bits [WIDTH-1:0].
REQ-008 Port: c_out  output  1  registered carry out of bit WIDTH-1.
REQ-009 Port: overflow  output  1  registered two's-complement overflow flag (carry into MSB XOR carry out of MSB).

Function
REQ-010 The adder SHALL be a ripple chain of WIDTH one-bit full-adder cells, cell i taking a[i], b[i] and carry c[i], with c[0] = cin.
REQ-011 Each cell SHALL produce s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
REQ-012 The combinational result SHALL equal {c[WIDTH], s} = a + b + cin, computed modulo 2^(WIDTH+1), with no truncation of the carry.
REQ-013 On every rising clk edge with reset low, sum SHALL load s, c_out SHALL load c[WIDTH], overflow SHALL load c[WIDTH] ^ c[WIDTH-1].
REQ-014 Latency SHALL be exactly 1 clock: outputs reflect the inputs sampled at the previous rising edge; a new operation is accepted every cycle.
REQ-015 Outputs SHALL hold their value between edges; input changes between edges SHALL NOT affect the outputs.
REQ-016 No handshake; every edge is a valid operation.
REQ-017 Boundary: all-ones a and b with cin = 1 SHALL give sum = all ones and c_out = 1. All-zero inputs SHALL give sum = 0 and c_out = 0.
REQ-018 For WIDTH = 1, overflow SHALL be computed with c[0] = cin as the carry into the MSB.
REQ-019 X/Z on inputs is out of scope; the design SHALL contain no latches and no internal state other than the output registers.

Reset
REQ-020 While reset is high at a rising edge, sum SHALL become 0, c_out 0 and overflow 0, regardless of a, b and cin.
REQ-021 Reset SHALL take priority over the addition at the same edge.
REQ-022 The first edge with reset low SHALL register the current a + b + cin normally; there are no extra flush cycles.
REQ-023 Asserting reset mid-stream SHALL discard the pending result at that edge.
REQ-024 Output values before the first reset edge are undefined.

Verification
REQ-025 Reset high for 2 edges with a=11, b=11, cin=1 -> sum=00, c_out=0, overflow=0.
REQ-026 Zero add, WIDTH=2 -> stimulus a=00, b=00, cin=0 -> one edge later sum=00, c_out=0, overflow=0.
REQ-027 Carry-out add, WIDTH=2 -> stimulus:
  - a=01, b=11, cin=0 -> sum=00, c_out=1, overflow=0.
  - a=11, b=11, cin=1 -> sum=11, c_out=1.
REQ-028 Carry-in add, WIDTH=2 -> stimulus a=10, b=01, cin=1 -> sum=00, c_out=1, overflow=0.
REQ-029 Back-to-back ops -> change inputs every cycle -> outputs track with exactly 1-cycle lag.
REQ-030 Inputs changed mid-cycle, then back before the edge -> no output change.
REQ-031 Reset asserted mid-stream -> outputs 0 at that edge.
REQ-032 Signed overflow, WIDTH=2 -> stimulus a=01, b=01, cin=0 -> sum=10, c_out=0, overflow=1.
REQ-033 Exhaustive sweep, WIDTH=4 -> all 512 combinations of a, b and cin -> every result matches a+b+cin.
